seq_restoring_divider: RTL and testbench

//  Sequential unsigned restoring divider. It computes quotient and remainder of a DIVIDEND_W-bit

---
 rtl/seq_restoring_divider_pkg.sv | 24 ++
 rtl/seq_restoring_divider_if.sv | 42 ++++
 rtl/seq_restoring_divider_div_step.sv | 30 +++
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// ============================================================================
// Module  : seq_restoring_divider_pkg
// Purpose : Shared definitions for the sequential restoring divider: default
//           operand widths and the controller state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_restoring_divider_pkg;

  // Dividend matches the 16-bit product of the 8x8 multiplier it inverts.
  localparam int unsigned c_dividend_w_def = 16;
  localparam int unsigned c_divisor_w_def  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
// ============================================================================
// Module  : seq_restoring_divider_if
// Purpose : Request/result bundle of the sequential restoring divider.
// Ports   : master - drives start/dividend/divisor, observes status + results
//           slave  - the divider; observes request, drives status + results
//           start, dividend, divisor            : request side
//           ready, busy, done                   : status
//           quotient, remainder, div_zero       : results (held until next op)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

import seq_restoring_divider_pkg::*;

interface seq_restoring_divider_if #(
  parameter int DIVIDEND_W = c_dividend_w_def,
  parameter int DIVISOR_W  = c_divisor_w_def
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational restoring-division step: compare the partial
//           remainder T against D and subtract when it fits.
// Ports   : i_t      [DIVISOR_W:0]   shifted partial remainder
//           i_d      [DIVISOR_W-1:0] divisor
//           o_r_next [DIVISOR_W-1:0] new partial remainder
//           o_qbit                   quotient bit produced by this step
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   i_t,
  input  logic [DIVISOR_W-1:0] i_d,
  output logic [DIVISOR_W-1:0] o_r_next,
  output logic                 o_qbit
);

  assign o_qbit = (i_t >= {1'b0, i_d});

  // The restored remainder is always < D, so it fits in DIVISOR_W bits; the
  // low-bit subtraction is exact modulo 2^DIVISOR_W whenever T >= D.
  assign o_r_next = o_qbit ? (i_t[DIVISOR_W-1:0] - i_d) : i_t[DIVISOR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module  : seq_restoring_divider
// Purpose : Sequential unsigned restoring divider, one quotient bit per clock.
//           Divide-by-zero completes immediately with quotient all-ones and
//           remainder = low bits of the dividend, flagged by div_zero.
// Ports   : clk      rising-edge clock
//           rst      synchronous active-high reset
//           div_bus  seq_restoring_divider_if.slave request/result bundle
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

import seq_restoring_divider_pkg::*;

module seq_restoring_divider #(
  parameter int DIVIDEND_W = c_dividend_w_def,
  parameter int DIVISOR_W  = c_divisor_w_def
) (
  input  logic                         clk,
  input  logic                         rst,
  seq_restoring_divider_if.slave       div_bus
);

  localparam int              CNT_W      = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIVIDEND_W - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_last_step;

  logic [CNT_W-1:0]      r_cnt;
  logic [DIVISOR_W-1:0]  r_d;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVIDEND_W-1:0] r_q;

  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_div_zero;

  logic [DIVISOR_W:0]    w_t;
  logic [DIVISOR_W-1:0]  w_r_next;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_q_next;

  // Q doubles as the dividend shift register: its MSB feeds the remainder
  // while the new quotient bit enters at the LSB.
  assign w_t      = {r_rem, r_q[DIVIDEND_W-1]};
  assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_div_step (
    .i_t      (w_t),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_qbit   (w_qbit)
  );

  assign w_last_step = (r_cnt == c_cnt_last);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_bus.start) begin
          w_accept     = 1'b1;
          w_state_next = (div_bus.divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_step) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_d         <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      // Status flags are registered copies of the upcoming state.
      r_ready <= (w_state_next == S_IDLE);
      r_busy  <= (w_state_next == S_CALC);
      r_done  <= (w_state_next == S_DONE);

      if (w_accept) begin
        r_d   <= div_bus.divisor;
        r_q   <= div_bus.dividend;
        r_rem <= '0;
        r_cnt <= '0;
        if (div_bus.divisor == '0) begin
          r_quotient  <= '1;
          r_remainder <= div_bus.dividend[DIVISOR_W-1:0];
          r_div_zero  <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_r_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last_step) begin
          r_quotient  <= w_q_next;
          r_remainder <= w_r_next;
          r_div_zero  <= 1'b0;
        end
      end
    end
  end

  assign div_bus.ready     = r_ready;
  assign div_bus.busy      = r_busy;
  assign div_bus.done      = r_done;
  assign div_bus.quotient  = r_quotient;
  assign div_bus.remainder = r_remainder;
  assign div_bus.div_zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module  : tb_seq_restoring_divider
// Purpose : Self-checking bench for seq_restoring_divider: directed vector
//           table, protocol/reset sequences and random back-to-back traffic
//           compared against plain-arithmetic division.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_restoring_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  seq_restoring_divider #(
    .DIVIDEND_W (16),
    .DIVISOR_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready && w < 50) begin
      tick();
      w++;
    end
    check("wait_ready_timeout", 32'(w >= 50), 32'd0);
  endtask

  // Starts one op and returns its results plus the cycle (1 = cycle after the
  // accepting edge) in which done was seen; lat = -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic dz, output int lat);
    wait_ready();
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) lat = -1;
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_zero;
  endtask

  initial begin
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
    int          cyc;
    logic        saw_done;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] exp_a[$];
    logic [7:0]  exp_b[$];
    int          n_done;
    int          last_done_cyc;
    int          bad_rand;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{16'd200,   8'd7,   16'd28,    8'd4,    1'b0, 17};
    vecs[1] = '{16'hFFFF,  8'h01,  16'hFFFF,  8'd0,    1'b0, 17};
    vecs[2] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,    1'b0, 17};
    vecs[3] = '{16'hFFFE,  8'hFF,  16'd256,   8'd254,  1'b0, 17};
    vecs[4] = '{16'd100,   8'd200, 16'd0,     8'd100,  1'b0, 17};
    vecs[5] = '{16'd0,     8'd9,   16'd0,     8'd0,    1'b0, 17};
    vecs[6] = '{16'h0105,  8'd0,   16'hFFFF,  8'h05,   1'b1, 1};
    vecs[7] = '{16'd10,    8'd3,   16'd3,     8'd1,    1'b0, 17};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("reset_ready",     32'(bus.ready),     32'd1);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_done",      32'(bus.done),      32'd0);
    check("reset_quotient",  32'(bus.quotient),  32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_div_zero",  32'(bus.div_zero),  32'd0);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, lat);
      check($sformatf("vec%0d_latency", i),   32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i),  32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(r),   32'(vecs[i].r));
      check($sformatf("vec%0d_div_zero", i),  32'(dz),  32'(vecs[i].dz));
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done),  32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(bus.ready), 32'd1);
      check($sformatf("vec%0d_q_held", i),     32'(bus.quotient), 32'(vecs[i].q));
    end

    // Start re-pulsed during CALC (cycle 3) and in the DONE cycle (17).
    wait_ready();
    bus.start = 1'b1; bus.dividend = 16'd200; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    check("proto_busy_c1", 32'(bus.busy), 32'd1);
    while (cyc < 17) begin
      tick();
      cyc++;
      if (cyc == 3) begin
        bus.start = 1'b1; bus.dividend = 16'd999; bus.divisor = 8'd5;
      end else if (cyc == 4) begin
        bus.start = 1'b0;
      end
    end
    check("proto_done_c17",  32'(bus.done),      32'd1);
    check("proto_quotient",  32'(bus.quotient),  32'd28);
    check("proto_remainder", 32'(bus.remainder), 32'd4);
    bus.start = 1'b1; bus.dividend = 16'd1234; bus.divisor = 8'd11;
    tick();
    bus.start = 1'b0;
    check("proto_c18_ready", 32'(bus.ready), 32'd1);
    check("proto_c18_done",  32'(bus.done),  32'd0);
    tick();
    check("proto_c19_busy",  32'(bus.busy),     32'd0);
    check("proto_c19_q",     32'(bus.quotient), 32'd28);

    // Reset in the middle of a calculation.
    wait_ready();
    bus.start = 1'b1; bus.dividend = 16'd200; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      tick();
      cyc++;
    end
    check("rst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ready",     32'(bus.ready),     32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_quotient",  32'(bus.quotient),  32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_zero",  32'(bus.div_zero),  32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);
    run_op(16'd10, 8'd3, q, r, dz, lat);
    check("post_rst_latency",   32'(lat), 32'd17);
    check("post_rst_quotient",  32'(q),   32'd3);
    check("post_rst_remainder", 32'(r),   32'd1);

    // Random back-to-back traffic with start held high. Operands are
    // re-randomised each cycle; when ready is seen the current pair is the
    // one the next edge latches, so it is recorded as the expected op.
    wait_ready();
    ra = 16'($urandom);
    rb = 8'($urandom_range(1, 255));
    bus.dividend = ra;
    bus.divisor  = rb;
    bus.start    = 1'b1;
    n_done        = 0;
    last_done_cyc = -1;
    bad_rand      = 0;
    for (int c = 0; c < 2000 * 18 + 100 && n_done < 2000; c++) begin
      if (bus.ready) begin
        exp_a.push_back(ra);
        exp_b.push_back(rb);
      end
      tick();
      if (bus.done) begin
        logic [15:0] ea;
        logic [7:0]  eb;
        if (exp_a.size() == 0) begin
          check("rand_unexpected_done", 32'd1, 32'd0);
        end else begin
          ea = exp_a.pop_front();
          eb = exp_b.pop_front();
          check("rand_quotient",  32'(bus.quotient),  32'(ea / 16'(eb)));
          check("rand_remainder", 32'(bus.remainder), 32'(ea % 16'(eb)));
          check("rand_invariant",
                32'(bus.quotient) * 32'(eb) + 32'(bus.remainder), 32'(ea));
          if (bus.div_zero) bad_rand++;
        end
        if (last_done_cyc >= 0) check("rand_throughput", 32'(c - last_done_cyc), 32'd18);
        last_done_cyc = c;
        n_done++;
      end
      if (!bus.ready) begin
        case ($urandom_range(0, 7))
          0:       ra = 16'hFFFF;
          1:       ra = 16'(8'($urandom));
          default: ra = 16'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0:       rb = 8'hFF;
          1:       rb = 8'h01;
          default: rb = 8'($urandom_range(1, 255));
        endcase
        bus.dividend = ra;
        bus.divisor  = rb;
      end
    end
    bus.start = 1'b0;
    check("rand_ops_completed", 32'(n_done), 32'd2000);
    check("rand_div_zero_flag", 32'(bad_rand), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
